// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the wait-stated APB memory slave.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(16);

  localparam int ERR_RANGE = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_RO    = 2;
  localparam int ERR_PROT  = 3;
  localparam int ERR_W     = 4;

  // Every bit of an erroring read carries this value.
  localparam logic ERR_FILL = 1'b1;

  function automatic logic in_window(input int unsigned idx,
                                     input int unsigned base,
                                     input int unsigned words);
    return (idx >= base) && (idx < base + words);
  endfunction

endpackage

// File: rtl/apb_mem_ram.sv
// Byte-enabled word memory with a registered read port that can be loaded,
// forced to the error pattern, or cleared to zero.
module apb_mem_ram
  import apb_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  localparam int unsigned NB = DATA_WIDTH / 8,
  localparam int unsigned AW = $clog2(MEM_DEPTH)
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [NB-1:0]         wr_be,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_load,
  input  logic                  rd_fill,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  // NOTE: the array is deliberately reset; a cleared bank after PRESETn is
  // part of the contract, so this cannot map onto a plain SRAM macro.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mem_q <= '{default: '0};
    end else begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wr_be[b]) mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_load) rd_data_d = rd_fill ? {DATA_WIDTH{ERR_FILL}} : mem_q[rd_addr];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) rd_data_q <= '0;
    else          rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB4 byte-strobed memory slave with programmable wait states and error
// response. Define APB_MEM_PROT_EN to enable privilege checking of the RO region.
module apb_mem_slave_ws
  import apb_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned RO_BASE     = 0,
  parameter int unsigned RO_WORDS    = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned AW    = $clog2(MEM_DEPTH);

  state_t            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [AW-1:0]     addr_d, addr_q;
  logic              write_d, write_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic [NB-1:0]     strb_d, strb_q;
  logic [ERR_W-1:0]  err_d, err_q;
  logic              pready_d, pready_q;
  logic              pslverr_d, pslverr_q;

  int unsigned       idx_live;
  logic [ERR_W-1:0]  err_live;
  logic [NB-1:0]     wr_be;
  logic              rd_load;

  logic unused_prot;
  assign unused_prot = ^PPROT;

  assign idx_live = 32'(PADDR) >> OFF_W;

  always_comb begin
    err_live = '0;
    err_live[ERR_RANGE] = idx_live >= MEM_DEPTH;
    err_live[ERR_ALIGN] = (PADDR & ADDR_WIDTH'(NB - 1)) != '0;
    err_live[ERR_RO]    = PWRITE && in_window(idx_live, RO_BASE, RO_WORDS);
`ifdef APB_MEM_PROT_EN
    err_live[ERR_PROT]  = !PPROT[0] && in_window(idx_live, RO_BASE, RO_WORDS);
`else
    err_live[ERR_PROT]  = 1'b0;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = AW'(idx_live);
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          err_d   = err_live;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        // Dropping PSEL mid-wait abandons the transfer without side effects.
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pready_d  = (state_d == RESP);
  assign pslverr_d = (state_d == RESP) && (err_d != '0);
  assign rd_load   = (state_d == RESP) && !write_d;
  assign wr_be     = (state_q == RESP && write_q && err_q == '0) ? strb_q : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  apb_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .wr_be   (wr_be),
    .wr_addr (addr_q),
    .wr_data (wdata_q),
    .rd_load (rd_load),
    .rd_fill (err_d != '0),
    .rd_addr (addr_d),
    .rd_data (PRDATA)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Directed plus randomized bench for apb_mem_slave_ws against a word-array
// reference model; honours APB_MEM_PROT_EN when defined.
module tb_apb_mem_slave_ws;

  localparam int unsigned AW_B  = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 2;
  localparam int unsigned ROB   = 0;
  localparam int unsigned ROW   = 4;
  localparam int          TMO   = 64;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [AW_B-1:0] PADDR;
  logic            PSEL, PENABLE, PWRITE;
  logic [DW-1:0]   PWDATA;
  logic [3:0]      PSTRB;
  logic [2:0]      PPROT;
  logic [DW-1:0]   PRDATA;
  logic            PREADY, PSLVERR;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_m [DEPTH];

  always #5 PCLK = ~PCLK;

  apb_mem_slave_ws #(
    .ADDR_WIDTH (AW_B), .DATA_WIDTH (DW), .MEM_DEPTH (DEPTH),
    .WAIT_STATES (WS), .RO_BASE (ROB), .RO_WORDS (ROW)
  ) dut (
    .PCLK (PCLK), .PRESETn (PRESETn), .PADDR (PADDR), .PSEL (PSEL),
    .PENABLE (PENABLE), .PWRITE (PWRITE), .PWDATA (PWDATA), .PSTRB (PSTRB),
    .PPROT (PPROT), .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [11:0] a, input logic w, input logic [2:0] p);
    int unsigned idx;
    logic ro, e;
    idx = int'(a) / 4;
    ro  = (idx >= ROB) && (idx < ROB + ROW);
    e   = (idx >= DEPTH) || (a % 4 != 0) || (w && ro);
`ifdef APB_MEM_PROT_EN
    e   = e || (ro && !p[0]);
`else
    if (p[0]) e = e;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, input logic [2:0] p);
    if (model_err(a, 1'b0, p)) return 32'hFFFF_FFFF;
    return mem_m[int'(a) / 4];
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p);
    if (!model_err(a, 1'b1, p))
      for (int b = 0; b < 4; b++)
        if (s[b]) mem_m[int'(a) / 4][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Drives the setup phase in the current cycle, then enters the access phase.
  task automatic apb_setup(input logic [11:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
    PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s; PPROT = p;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
  endtask

  // Counts access cycles with PREADY low; stops inside the completing cycle.
  task automatic apb_wait_ready(output int waits);
    waits = 0;
    while (PREADY !== 1'b1 && waits <= TMO) begin
      waits++;
      @(posedge PCLK); #1;
    end
    if (waits > TMO) chk("pready_timeout", 32'(PREADY), 32'd1);
  endtask

  task automatic apb_xfer(input string tag, input logic [11:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                          input logic chk_rdata, output logic [31:0] rdata);
    int waits;
    logic exp_err;
    logic [31:0] exp_rd;
    exp_err = model_err(a, w, p);
    exp_rd  = model_read(a, p);
    apb_setup(a, w, d, s, p);
    apb_wait_ready(waits);
    rdata = PRDATA;
    chk({tag, "_waits"}, 32'(waits), 32'(WS));
    chk({tag, "_slverr"}, 32'(PSLVERR), 32'(exp_err));
    if (!w && chk_rdata) chk({tag, "_rdata"}, PRDATA, exp_rd);
    if (w) model_write(a, d, s, p);
    @(posedge PCLK); #1;
    chk({tag, "_ready_pulse"}, 32'(PREADY), 32'd0);
    chk({tag, "_slverr_pulse"}, 32'(PSLVERR), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [11:0] a;
    logic [2:0]  p;
    int          waits;
    int          r;

    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
    #23;
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Basic write then read-back with two wait states.
    apb_xfer("wr10", 12'h010, 1'b1, 32'hA5A5_1234, 4'hF, 3'b001, 1'b0, rd);
    apb_xfer("rd10", 12'h010, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd);
    chk("rd10_value", rd, 32'hA5A5_1234);

    // Byte strobes.
    apb_xfer("wr20", 12'h020, 1'b1, 32'h1122_3344, 4'hF, 3'b001, 1'b0, rd);
    apb_xfer("wr20s", 12'h020, 1'b1, 32'hFFFF_FFFF, 4'b0101, 3'b001, 1'b0, rd);
    apb_xfer("rd20", 12'h020, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd);
    chk("rd20_value", rd, 32'h11FF_33FF);

    // Out-of-range read and misaligned write.
    apb_xfer("rd400", 12'h400, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd);
    chk("rd400_fill", rd, 32'hFFFF_FFFF);
    apb_xfer("wr13", 12'h013, 1'b1, 32'h0BAD_0BAD, 4'hF, 3'b001, 1'b0, rd);
    apb_xfer("rd10b", 12'h010, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd);
    chk("word4_kept", rd, 32'hA5A5_1234);

    // Read-only region.
    apb_xfer("wr04", 12'h004, 1'b1, 32'hDEAD_0000, 4'hF, 3'b001, 1'b0, rd);
    apb_xfer("rd04p1", 12'h004, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd);
    chk("word1_zero", rd, 32'h0);
    apb_xfer("rd04p0", 12'h004, 1'b0, 32'h0, 4'h0, 3'b000, 1'b1, rd);

    // Zero-strobe write is legal and changes nothing.
    apb_xfer("wr10z", 12'h010, 1'b1, 32'h0, 4'h0, 3'b001, 1'b0, rd);
    apb_xfer("rd10z", 12'h010, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd);

    // Abort: PSEL dropped in the first wait cycle; next cycle is a fresh setup.
    apb_setup(12'h030, 1'b1, 32'h55, 4'hF, 3'b001);
    chk("abort_ready_c1", 32'(PREADY), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      chk("abort_ready_idle", 32'(PREADY), 32'd0);
    end
    apb_xfer("rd30", 12'h030, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd);
    chk("rd30_value", rd, 32'h0);

    // Reset asserted while a read response is on the bus.
    apb_setup(12'h010, 1'b0, 32'h0, 4'h0, 3'b001);
    apb_wait_ready(waits);
    chk("pre_rst_rdata", PRDATA, 32'hA5A5_1234);
    PRESETn = 1'b0; #1;
    chk("rst_resp_pready", 32'(PREADY), 32'd0);
    chk("rst_resp_prdata", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; #1;
    PRESETn = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
    @(posedge PCLK); #1;

    // Reset asserted during the wait of a write.
    apb_setup(12'h040, 1'b1, 32'h1234_5678, 4'hF, 3'b001);
    PRESETn = 1'b0; #1;
    chk("rst_wait_pready", 32'(PREADY), 32'd0);
    chk("rst_wait_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_wait_prdata", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    apb_xfer("post_rd40", 12'h040, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd);
    apb_xfer("post_rd20", 12'h020, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd);
    chk("post_rd20_zero", rd, 32'h0);

    // Randomized mix against the reference model.
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      a = 12'($urandom_range(0, 15) * 4);
      if (r == 0) a = 12'h400 + 12'($urandom_range(0, 255) * 4);
      else if (r == 1) a = a + 12'($urandom_range(1, 3));
      p = 3'($urandom_range(0, 7));
      apb_xfer("rnd", a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
               p, 1'b1, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave_ws.md
# apb_mem_slave_ws

Next-generation APB4 memory-mapped slave: a word-organised, byte-strobed register/memory bank with byte addressing, a programmable number of wait states, and full error signalling. Errors cover out-of-range, misaligned and read-only-region accesses, with optional privilege checking. It sits on the peripheral APB segment behind the bridge and replaces the single-cycle, always-ready memory slave wherever slow storage or protection is needed.

## Interface
- ADDR_WIDTH, 12: byte-address width of PADDR.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- MEM_DEPTH, 256: number of DATA_WIDTH words.
- WAIT_STATES, 2: PREADY-low cycles inserted per access; legal range 0..15.
- RO_BASE, 0: first word index of the read-only region.
- RO_WORDS, 4: size of the read-only region in words; 0 disables the region.
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- PADDR  in  ADDR_WIDTH  byte address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte strobes.
- PPROT  in  3  protection attributes; bit 0 = privileged.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer complete, registered.
- PSLVERR  out  1  error response, registered.

## Operation
- Word index = PADDR >> log2(DATA_WIDTH/8).
- FSM states:
  - IDLE: a setup phase (PSEL=1, PENABLE=0) latches address, PWRITE, PWDATA, PSTRB and the error decode. If WAIT_STATES>0, load the counter with WAIT_STATES and go to WAIT; otherwise go to RESP.
  - WAIT: decrement the counter each cycle while PSEL=1. When the counter reaches 1, go to RESP. If PSEL=0, abort to IDLE with no side effects.
  - RESP: PREADY=1. Return to IDLE at the next edge.
- Error conditions, with their latched OR forming PSLVERR in RESP:
  - Word index >= MEM_DEPTH.
  - Misaligned address: low address bits nonzero.
  - Write to the word range [RO_BASE, RO_BASE+RO_WORDS).
  - Protection violation, only when the Configuration macro is defined.
- Write with no error: on the edge that leaves RESP, each byte lane whose PSTRB bit is 1 is updated; other lanes hold. Write with error: memory is unchanged.
- Read: PRDATA is loaded on entry to RESP. It carries mem[index] when there is no error and all-ones on error. PRDATA is 0 in every other state.
- A write with PSTRB=0 is legal and completes with no change and no error.
- The FSM uses the latched copies of the transfer signals. Changes to PADDR, PWRITE or PWDATA during WAIT are ignored.

## Timing
- Reset state: state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, counter 0, all memory words 0.
- Access length: the transfer completes in access-phase cycle WAIT_STATES+1. With WAIT_STATES=0, PREADY=1 in the first access cycle, giving zero-wait APB timing.
- PREADY and PSLVERR are high for exactly one cycle per completed transfer.
- Back-to-back transfers: RESP goes to IDLE, and the next setup phase is accepted in that IDLE cycle. There are no dead cycles beyond the APB protocol itself.
- Reset asserted mid-WAIT or mid-RESP: the pending write is discarded and all outputs take their reset values immediately (asynchronous).
- Setup phase asserted while in WAIT (protocol violation): the new setup is ignored.

## Configuration
- APB_MEM_PROT_EN defined: an access of either direction to the RO region with PPROT[0]=0 raises PSLVERR. An erroring read returns all-ones, and no data leaks.
- APB_MEM_PROT_EN undefined: PPROT is ignored. The RO region is readable by all and unwritable by all.

## Structure
- Package apb_mem_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the WAIT counter width, $clog2(16);
  - the error-cause bit positions (RANGE, ALIGN, RO, PROT) as localparams;
  - the error read pattern.
- Sub-module apb_mem_ram: a MEM_DEPTH x DATA_WIDTH array with a byte-enable write port, a synchronous read port, and asynchronous clear on PRESETn.

## Test plan
- WAIT_STATES=2: write 0xA5A51234 to 0x010 with PSTRB=0xF. PREADY must be low for 2 access cycles and high on the 3rd. Reading 0x010 must then return 0xA5A51234 with PSLVERR=0.
- Strobed write: with 0x11223344 at 0x020, write 0xFFFFFFFF with PSTRB=0b0101. A read must return 0x11FF33FF.
- Out of range and misaligned:
  - Read of 0x400 must give PSLVERR=1 and PRDATA=0xFFFFFFFF.
  - Write of 0x013 must give PSLVERR=1 and leave word 4 unchanged.
- RO region with RO_BASE=0, RO_WORDS=4:
  - Write 0xDEAD0000 to 0x004: PSLVERR=1 and word 1 reads 0.
  - With APB_MEM_PROT_EN, a read of 0x004 with PPROT=0 gives PSLVERR=1.
  - With APB_MEM_PROT_EN, a read of 0x004 with PPROT=1 gives PSLVERR=0.
- Abort: write 0x55 to 0x030, then drop PSEL in the first WAIT cycle. PREADY must never assert, the FSM must be in IDLE next cycle, and a read of 0x030 must return 0.
- Reset mid-access: assert PRESETn=0 during WAIT of a write. All outputs must be 0 at once, the memory must be all-zero, and the next transfer must be accepted normally.
